// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned INST_W     = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    BOOT,
    RUN
  } fetch_state_t;

  // One buffered fetch: the PC field is ADDR_W_DEF wide, so the top supports ADDR_W up to that width.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INST_W-1:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO of fetch entries with synchronous clear.
// Clear wins over push; push when full and pop when empty are ignored.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != CNT_W'(0));
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; no reset needed because empty slots are never presented.
  always_ff @(posedge clk) begin
    if (!rst && !clr && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, credit-limited imem requests, prefetch FIFO,
// redirect flush. Optional performance counters are enabled with FETCH_PERF_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC) & ~ADDR_W'(3);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pending_pc;
  logic              pending;
  logic              kill;
  logic [CNT_W-1:0]  fifo_count;
  fetch_entry_t      head;
  fetch_entry_t      entry;
  logic              credit;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] target_pc;

  // A slot must exist for every outstanding request, counting the one landing this cycle.
  assign credit    = (SUM_W'(fifo_count) + SUM_W'(pending)) < SUM_W'(DEPTH);
  assign imem_req  = !rst && !redirect_valid && credit;
  assign imem_addr = fetch_pc;
  assign target_pc = redirect_pc & ~ADDR_W'(3);

  // A response is buffered unless its fetch was killed or a flush happens this cycle.
  assign push       = (state_q == RUN) && pending && !kill && !redirect_valid;
  assign pop        = inst_valid && inst_ready;
  assign entry.pc   = ADDR_W_DEF'(pending_pc);
  assign entry.inst = imem_rdata;

  assign inst_valid = (fifo_count != CNT_W'(0));
  assign inst_data  = inst_valid ? head.inst : NOP_INST;
  assign inst_pc    = inst_valid ? ADDR_W'(head.pc) : '0;

  // Boot/run state, PC sequencing and in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc   <= START_PC;
      pending_pc <= START_PC;
      pending    <= 1'b0;
      kill       <= 1'b0;
    end else begin
      state_q <= RUN;
      pending <= imem_req;
      kill    <= redirect_valid;
      if (imem_req) pending_pc <= fetch_pc;
      if (redirect_valid) begin
        fetch_pc <= target_pc;
      end else if (imem_req) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clr   (redirect_valid),
    .wdata (entry),
    .rdata (head),
    .count (fifo_count)
  );

`ifdef FETCH_PERF_EN
  // Saturating counters for request-starved cycles and redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if ((state_q == RUN) && !imem_req && !redirect_valid && (perf_stall_cnt != 16'hFFFF))
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (redirect_valid && (perf_flush_cnt != 16'hFFFF))
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decoder and controller. Sequences the byte-addressed 12-bit PC and issues word requests to the synchronous instruction memory, which returns data one cycle after the request. Buffers returned words with their PCs in a small prefetch FIFO and presents them to decode over a valid/ready handshake. Accepts branch/jump redirects from the branch decision logic, flushing buffered and in-flight fetches.

## Interface
- `DEPTH`, default 4: prefetch FIFO entries, a power of two, minimum 2.
- `ADDR_W`, default 12: PC/address width in bytes.
- `RESET_PC`, default 0: first fetch address after reset; word aligned.
- `clk` in, 1 bit: single clock, rising edge.
- `rst` in, 1 bit: synchronous, active-high reset.
- `imem_req` out, 1 bit: fetch request this cycle.
- `imem_addr` out, ADDR_W bits: byte address of the requested word; always word aligned.
- `imem_rdata` in, 32 bits: instruction word, valid the cycle after `imem_req`.
- `redirect_valid` in, 1 bit: taken branch or jump this cycle.
- `redirect_pc` in, ADDR_W bits: redirect target; bits [1:0] are masked to 0.
- `inst_valid` out, 1 bit: FIFO head is valid.
- `inst_data` out, 32 bits: instruction at the FIFO head.
- `inst_pc` out, ADDR_W bits: PC of `inst_data`.
- `inst_ready` in, 1 bit: decode accepts the head.

## Operation
- State machine:
  - BOOT: entered while `rst` is high. No request is issued. Moves to RUN on the first cycle with `rst` low.
  - RUN: normal operation. There is no other state.
- Request rule in RUN: `imem_req = !redirect_valid && (count + pending < DEPTH)`.
  - `count` is the FIFO occupancy.
  - `pending` is 1 when a response is due this cycle.
- On each issued request: `fetch_pc <= fetch_pc + 4`, modulo 2^ADDR_W. The PC wraps from 0xFFC to 0x000 with no flag.
- Response handling: when `pending` is set and `kill` is clear, push {`imem_rdata`, `pending_pc`} into the FIFO.
- Pop: when `inst_valid && inst_ready`. Push and pop in the same cycle leave `count` unchanged.
- Redirect in cycle N:
  - `fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}`.
  - The FIFO is cleared at the end of cycle N.
  - `kill` is set for cycle N+1, so a response arriving then is dropped.
  - No request is issued in cycle N.
- Redirect coinciding with a pop: the handshake completes (decode consumed that head), then the flush applies.
- Redirect coinciding with a push: the push is discarded.
- Back-to-back redirects: the last one wins. Each redirect suppresses that cycle's request.
- The FIFO never overflows, by the credit rule. A response is never dropped except by `kill`.
- Reset values:
  - `imem_req=0`, `imem_addr=RESET_PC`.
  - `inst_valid=0`, `inst_data=32'h00000013` (NOP), `inst_pc=0`.
  - `count=0`, `pending=0`, `kill=0`.
- Reset mid-operation: all in-flight and buffered state is discarded on the reset edge. A response arriving the cycle after reset is ignored.

## Timing
- `imem_addr` is driven from the `fetch_pc` register. `imem_req` is combinational from `count`, `pending` and `redirect_valid`.
- Reset release: the first request for RESET_PC goes out in the first cycle with `rst` low (cycle 0). Data returns in cycle 1. `inst_valid` first rises in cycle 2.
- Redirect latency: redirect in cycle N, request in N+1, data in N+2, `inst_valid` with `inst_pc = target` in N+3.
- Sustained throughput is one instruction per cycle while `inst_ready` stays high.
- `inst_valid`, `inst_data` and `inst_pc` are driven from FIFO storage with no combinational path from `imem_rdata`.
- Once `inst_valid` is high, the head holds stable until a pop, a redirect or a reset.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds output `perf_stall_cnt`, 16 bits: counts RUN cycles with `imem_req=0` and no redirect.
  - Adds output `perf_flush_cnt`, 16 bits: counts redirects.
  - Both counters saturate at 0xFFFF and reset to 0.
- `FETCH_PERF_EN` undefined: neither the ports nor the logic exist. All other behaviour is identical.

## Structure
- Package `fetch_pkg` holds:
  - `ADDR_W_DEF` (12) and `INST_W` (32).
  - `NOP_INST` (`32'h00000013`).
  - The `fetch_state_t` enum {BOOT, RUN}.
  - A packed `fetch_entry_t` of {pc, inst}.
- Sub-module `fetch_fifo`: DEPTH-entry circular buffer of `fetch_entry_t`.
  - Push, pop and synchronous clear.
  - Clear has priority over push.
  - Exports `count`.

## Test plan
- Reset with RESET_PC=0x010, `inst_ready=1`, imem model returning addr|0xAB000000 → heads 0x010, 0x014, 0x018 on consecutive cycles, first `inst_valid` 2 cycles after `rst` falls.
- Hold `inst_ready=0` for 10 cycles → exactly 4 entries buffered. `imem_req` stays 0 with FIFO full and no response pending. Order is preserved on release.
- Redirect to 0x103 while one response is in flight and 3 entries are buffered → FIFO empties, in-flight word dropped, next `imem_addr`=0x100, `inst_pc`=0x100 valid 3 cycles after the redirect.
- Redirect in the same cycle as a pop of PC 0x020 → 0x020 is counted as consumed, no stale entry (0x024) ever appears after the redirect.
- Start at 0xFF8 streaming → `inst_pc` sequence 0xFF8, 0xFFC, 0x000, 0x004.
- With `FETCH_PERF_EN`: 5 redirects and 7 full-stall cycles → `perf_flush_cnt`=5, `perf_stall_cnt`=7. Assert `rst` mid-stream → both read 0 the next cycle, along with `inst_valid`=0.
